// File: rtl/addon_slice_sequencer.sv
// Purpose : time-shares one external SLICE_W-bit adder slice between NUM_REQ requesters, chaining carry across beats.
// Latency : one cycle from beat accept to registered result; one idle bubble cycle per transaction for arbitration.
// Backpressure: a held result (res_valid & !res_ready) drops req_ready of the owning requester; others wait for the lock.
//
// Ports:
//   clk, rst_n                 clock (rising edge) and synchronous active-low reset
//   req_valid/ready/a/b/cin/last  per-requester beat interface; slices packed at [i*SLICE_W +: SLICE_W]
//   slice_a/b/cin              operands driven to the external combinational adder slice
//   slice_sum/cout             adder slice outputs
//   res_valid/ready            result handshake
//   res_sum/cout/last/trunc/id registered result slice and its transaction flags / owner
module addon_slice_sequencer #(
    parameter int SLICE_W   = 3,
    parameter int NUM_REQ   = 2,
    parameter int MAX_BEATS = 4,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BCW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*SLICE_W-1:0] req_a,
    input  logic [NUM_REQ*SLICE_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]         req_cin,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [SLICE_W-1:0]         slice_a,
    output logic [SLICE_W-1:0]         slice_b,
    output logic                       slice_cin,
    input  logic [SLICE_W-1:0]         slice_sum,
    input  logic                       slice_cout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [SLICE_W-1:0]         res_sum,
    output logic                       res_cout,
    output logic                       res_last,
    output logic                       res_trunc,
    output logic [IDW-1:0]             res_id
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]         r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_grant;
    logic               r_carry;
    logic [BCW-1:0]     r_beat_cnt;

    logic               r_res_valid;
    logic [SLICE_W-1:0] r_res_sum;
    logic               r_res_cout;
    logic               r_res_last;
    logic               r_res_trunc;
    logic [IDW-1:0]     r_res_id;

    logic               w_lock;
    logic               w_res_free;
    logic               w_accept;
    logic               w_first;
    logic               w_end;
    logic               w_trunc;
    logic               w_any;
    logic [IDW-1:0]     w_pick;
    logic [IDW-1:0]     w_cand;
    logic [IDW-1:0]     w_rr_next;
    logic [SLICE_W-1:0] w_gnt_a;
    logic [SLICE_W-1:0] w_gnt_b;
    logic               w_gnt_valid;
    logic               w_gnt_cin;
    logic               w_gnt_last;

    // Select the granted requester's beat fields.
    always_comb begin
        w_gnt_a     = '0;
        w_gnt_b     = '0;
        w_gnt_valid = 1'b0;
        w_gnt_cin   = 1'b0;
        w_gnt_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(r_grant) == i) begin
                w_gnt_a     = req_a[i*SLICE_W +: SLICE_W];
                w_gnt_b     = req_b[i*SLICE_W +: SLICE_W];
                w_gnt_valid = req_valid[i];
                w_gnt_cin   = req_cin[i];
                w_gnt_last  = req_last[i];
            end
        end
    end

    // Round-robin pick: scan from rr_ptr upward. The loop runs downward so the
    // candidate closest to rr_ptr is written last and wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_lock     = (r_state == ST_LOCK);
    // The result register can take a new beat if empty or being drained this cycle.
    assign w_res_free = !r_res_valid || res_ready;
    assign w_accept   = w_lock && w_gnt_valid && w_res_free;
    assign w_first    = (r_beat_cnt == '0);
    assign w_end      = w_gnt_last || (r_beat_cnt == BCW'(MAX_BEATS - 1));
    assign w_trunc    = !w_gnt_last && (r_beat_cnt == BCW'(MAX_BEATS - 1));
    assign w_rr_next  = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + IDW'(1);

    always_comb begin
        req_ready = '0;
        if (w_lock) begin
            req_ready[r_grant] = w_res_free;
        end
    end

    assign slice_a   = w_lock ? w_gnt_a : '0;
    assign slice_b   = w_lock ? w_gnt_b : '0;
    assign slice_cin = w_lock && (w_first ? w_gnt_cin : r_carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_carry     <= 1'b0;
            r_beat_cnt  <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_last  <= 1'b0;
            r_res_trunc <= 1'b0;
            r_res_id    <= '0;
        end else begin
            // Result register: a new accept reloads it even while draining.
            if (w_accept) begin
                r_res_valid <= 1'b1;
                r_res_sum   <= slice_sum;
                r_res_cout  <= slice_cout;
                r_res_last  <= w_end;
                r_res_trunc <= w_trunc;
                r_res_id    <= r_grant;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_LOCK;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_carry <= slice_cout;
                        if (w_end) begin
                            r_beat_cnt <= '0;
                            r_rr_ptr   <= w_rr_next;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BCW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_last  = r_res_last;
    assign res_trunc = r_res_trunc;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_addon_slice_sequencer.sv
// Purpose : self-checking bench for addon_slice_sequencer with an external 3-bit adder model.
// Latency : expects each accepted beat to show as res_valid in the following cycle.
// Backpressure: drives res_ready low for a window to confirm held results and dropped req_ready.
module tb_addon_slice_sequencer;

    localparam int SW = 3;
    localparam int NR = 2;
    localparam int MB = 4;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       last;
        logic [2:0] e_sum;
        logic       e_cout;
        logic       e_last;
        logic       e_trunc;
    } beat_t;

    typedef struct packed {
        logic [2:0] sum;
        logic       cout;
        logic       last;
        logic       trunc;
        logic       id;
    } res_t;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [5:0]    req_a;
    logic [5:0]    req_b;
    logic [NR-1:0] req_cin;
    logic [NR-1:0] req_last;
    logic [2:0]    slice_a;
    logic [2:0]    slice_b;
    logic          slice_cin;
    logic [2:0]    slice_sum;
    logic          slice_cout;
    logic          res_valid;
    logic          res_ready;
    logic [2:0]    res_sum;
    logic          res_cout;
    logic          res_last;
    logic          res_trunc;
    logic          res_id;

    addon_slice_sequencer #(.SLICE_W(SW), .NUM_REQ(NR), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_sum(slice_sum), .slice_cout(slice_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_last(res_last),
        .res_trunc(res_trunc), .res_id(res_id)
    );

    // External combinational adder slice.
    assign {slice_cout, slice_sum} = 4'(slice_a) + 4'(slice_b) + 4'(slice_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_run;
    int    n_fail;
    beat_t bq0[$];
    beat_t bq1[$];
    res_t  exp_q[$];
    res_t  res_log[$];
    logic  acc_cin[$];
    int    acc_cyc[$];
    int    rd_idx;
    int    gcyc;
    bit    acc_flag;
    bit    prev_stall;
    res_t  hold;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_run++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    task automatic chk_log(input int i, input string nm, input res_t e);
        if (i < res_log.size()) check(nm, 32'(res_log[i]), 32'(e));
        else fail({nm, " (result missing)"});
    endtask

    task automatic chk_cin(input int i, input string nm, input logic e);
        if (i < acc_cin.size()) check(nm, 32'(acc_cin[i]), 32'(e));
        else fail({nm, " (accept missing)"});
    endtask

    // Model: each transaction segment (at most MB beats) is one wide addition;
    // beat k's expected slice is read straight out of the wide sum.
    task automatic load(input int r, input int n, input logic [23:0] A, input logic [23:0] B,
                        input logic cin, input bit set_last);
        beat_t       bt;
        int          s;
        logic        c_seg;
        logic        prev_cout;
        logic [31:0] v;
        logic [31:0] mask;
        c_seg     = cin;
        prev_cout = 1'b0;
        for (int k = 0; k < n; k++) begin
            s       = (k / MB) * MB;
            bt.a    = A[3*k +: 3];
            bt.b    = B[3*k +: 3];
            // Later beats drive the inverse of the true carry so a DUT that
            // samples req_cin past the first beat gets a wrong sum.
            bt.cin  = (k == 0) ? cin : ~prev_cout;
            bt.last = set_last && (k == n - 1);
            if (k == s) c_seg = bt.cin;
            mask       = (32'd1 << (3 * (k - s + 1))) - 32'd1;
            v          = ((32'(A) >> (3 * s)) & mask) + ((32'(B) >> (3 * s)) & mask) + 32'(c_seg);
            bt.e_sum   = 3'(v >> (3 * (k - s)));
            bt.e_cout  = v[3 * (k - s + 1)];
            bt.e_last  = bt.last || (k - s == MB - 1);
            bt.e_trunc = (k - s == MB - 1) && !bt.last;
            prev_cout  = bt.e_cout;
            if (r == 0) bq0.push_back(bt);
            else        bq1.push_back(bt);
        end
    endtask

    // Present queued beats cycle by cycle; res_ready is low for cycles [st_from, st_to).
    task automatic run(input int st_from, input int st_to);
        int cyc;
        bit tk0;
        bit tk1;
        cyc = 0;
        while ((bq0.size() > 0 || bq1.size() > 0) && cyc < 300) begin
            req_valid = {bq1.size() > 0, bq0.size() > 0};
            if (bq0.size() > 0) begin
                req_a[2:0] = bq0[0].a; req_b[2:0] = bq0[0].b;
                req_cin[0] = bq0[0].cin; req_last[0] = bq0[0].last;
            end
            if (bq1.size() > 0) begin
                req_a[5:3] = bq1[0].a; req_b[5:3] = bq1[0].b;
                req_cin[1] = bq1[0].cin; req_last[1] = bq1[0].last;
            end
            res_ready = !(cyc >= st_from && cyc < st_to);
            @(negedge clk);
            tk0 = req_valid[0] && req_ready[0];
            tk1 = req_valid[1] && req_ready[1];
            if (tk0 && tk1) fail("two_grants_at_once");
            if (tk0 || tk1) begin
                acc_cin.push_back(slice_cin);
                acc_cyc.push_back(gcyc);
            end
            @(posedge clk);
            #1;
            if (tk0) begin
                exp_q.push_back({bq0[0].e_sum, bq0[0].e_cout, bq0[0].e_last, bq0[0].e_trunc, 1'b0});
                void'(bq0.pop_front());
            end else if (tk1) begin
                exp_q.push_back({bq1[0].e_sum, bq1[0].e_cout, bq1[0].e_last, bq1[0].e_trunc, 1'b1});
                void'(bq1.pop_front());
            end
            acc_flag = tk0 || tk1;
            cyc++;
            gcyc++;
        end
        if (cyc >= 300) begin
            fail("run_timeout");
            bq0.delete();
            bq1.delete();
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            acc_flag = 1'b0;
            gcyc++;
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        check({nm, "_res_valid"}, 32'(res_valid), 32'd0);
        check({nm, "_res_fields"}, 32'({res_sum, res_cout, res_last, res_trunc, res_id}), 32'd0);
        check({nm, "_req_ready"}, 32'(req_ready), 32'd0);
        check({nm, "_slice"}, 32'({slice_a, slice_b, slice_cin}), 32'd0);
    endtask

    initial begin
        int  t;
        bit  tk;
        n_run = 0; n_fail = 0; rd_idx = 0; gcyc = 0;
        acc_flag = 1'b0; prev_stall = 1'b0; hold = '0;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        req_cin = '0; req_last = '0; res_ready = 1'b1;

        // Per-cycle comparison against the model's expected result stream.
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    rd_idx     = exp_q.size();
                    prev_stall = 1'b0;
                end else begin
                    if (acc_flag) check("latency_res_valid", 32'(res_valid), 32'd1);
                    if (prev_stall)
                        check("held_result_stable",
                              32'({res_valid, res_sum, res_cout, res_last, res_trunc, res_id}),
                              32'({1'b1, hold}));
                    if (res_valid && !res_ready) begin
                        check("stall_req_ready", 32'(req_ready), 32'd0);
                        hold       = {res_sum, res_cout, res_last, res_trunc, res_id};
                        prev_stall = 1'b1;
                    end else begin
                        prev_stall = 1'b0;
                    end
                    if (res_valid && res_ready) begin
                        if (rd_idx < exp_q.size()) begin
                            check("result", 32'({res_sum, res_cout, res_last, res_trunc, res_id}),
                                  32'(exp_q[rd_idx]));
                            rd_idx++;
                        end else begin
                            fail("unexpected_result");
                        end
                        res_log.push_back({res_sum, res_cout, res_last, res_trunc, res_id});
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // 1: single beat on req0, 5+3+0 = 8.
        load(0, 1, 24'o5, 24'o3, 1'b0, 1'b1);
        run(0, 0);
        chk_log(0, "t1_single_beat", {3'd0, 1'b1, 1'b1, 1'b0, 1'b0});

        // 2: two-beat chain on req1, carry propagates into beat 2.
        load(1, 2, 24'o07, 24'o01, 1'b0, 1'b1);
        run(0, 0);
        chk_log(1, "t2_beat1", {3'd0, 1'b1, 1'b0, 1'b0, 1'b1});
        chk_log(2, "t2_beat2", {3'd1, 1'b0, 1'b1, 1'b0, 1'b1});
        chk_cin(2, "t2_beat2_slice_cin", 1'b1);

        // 3: both requesters contend, two single-beat jobs each.
        load(0, 1, 24'o1, 24'o2, 1'b0, 1'b1);
        load(0, 1, 24'o6, 24'o3, 1'b1, 1'b1);
        load(1, 1, 24'o4, 24'o4, 1'b1, 1'b1);
        load(1, 1, 24'o0, 24'o7, 1'b0, 1'b1);
        run(0, 0);
        chk_log(3, "t3_order0", {3'd3, 1'b0, 1'b1, 1'b0, 1'b0});
        chk_log(4, "t3_order1", {3'd1, 1'b1, 1'b1, 1'b0, 1'b1});
        chk_log(5, "t3_order2", {3'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        chk_log(6, "t3_order3", {3'd7, 1'b0, 1'b1, 1'b0, 1'b1});
        for (int i = 3; i < 6; i++)
            if (i + 1 < acc_cyc.size()) check("t3_idle_bubble", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd2);
            else fail("t3_idle_bubble (accept missing)");

        // 4: three-beat job with res_ready low for five cycles after the first result.
        load(0, 3, 24'o653, 24'o124, 1'b1, 1'b1);
        run(2, 7);
        check("t4_result_count", 32'(res_log.size()), 32'd10);
        chk_log(9, "t4_beat3", {3'd0, 1'b1, 1'b1, 1'b0, 1'b0});

        // 5: five beats, the first four without last: truncation, then a fresh job.
        load(0, 5, 24'o77777, 24'o0, 1'b1, 1'b1);
        run(0, 0);
        chk_cin(11, "t5_beat2_uses_carry", 1'b1);
        chk_log(13, "t5_beat4_trunc", {3'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        chk_cin(14, "t5_beat5_uses_req_cin", 1'b0);
        chk_log(14, "t5_beat5_new_job", {3'd7, 1'b0, 1'b1, 1'b0, 1'b0});

        // 6: reset while req1's job is mid-flight (rr_ptr points at req1 beforehand).
        res_ready = 1'b0;
        req_valid = 2'b10; req_a[5:3] = 3'd1; req_b[5:3] = 3'd1;
        req_cin[1] = 1'b0; req_last[1] = 1'b0;
        t = 0; tk = 1'b0;
        while (!tk && t < 20) begin
            @(negedge clk);
            tk = req_ready[1];
            @(posedge clk);
            #1;
            t++;
        end
        if (!tk) fail("t6_first_beat_timeout");
        req_a[5:3] = 3'd2; req_b[5:3] = 3'd2;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0; req_valid = '0; res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_outputs("t6_after_reset");
        rst_n = 1'b1;
        load(0, 1, 24'o0, 24'o0, 1'b1, 1'b1);
        load(1, 1, 24'o3, 24'o4, 1'b0, 1'b1);
        run(0, 0);
        chk_log(15, "t6_rr_restart_req0", {3'd1, 1'b0, 1'b1, 1'b0, 1'b0});
        chk_log(16, "t6_then_req1", {3'd7, 1'b0, 1'b1, 1'b0, 1'b1});
        chk_cin(15, "t6_uses_req_cin", 1'b1);

        check("all_results_seen", 32'(rd_idx), 32'(exp_q.size()));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
